// File: rtl/mic_volume_meter.sv
// mic_volume_meter
//   Measures the peak amplitude of 12-bit offset-binary mic samples over
//   fixed windows of WINDOW sample strobes. Each window's peak is quantised
//   to a 4-bit volume level and a 15-LED thermometer bar.
//
// Build option:
//   PEAK_HOLD_EN  when defined, a HOLD/DECAY FSM keeps a loud level on
//                 display for HOLD_WINDOWS windows and then lets it fall by
//                 one step per window. When undefined, the level follows
//                 each window's peak directly.
//
// Ports:
//   CLK          system clock
//   resetn       asynchronous active-low reset, released synchronously inside
//   samp_clk     sample clock, asynchronous to CLK; its rising edge marks a sample
//   mic_in[11:0] current mic sample, unsigned offset-binary
//   level[3:0]   displayed volume level 0..15
//   led_bar[14:0] thermometer, led_bar[i] = (i < level)
//   level_valid  one-CLK pulse whenever level/led_bar are updated
`timescale 1ns/1ps

module mic_volume_meter #(
  parameter int WINDOW       = 4000,
  parameter int MIDPOINT     = 2048,
  parameter int NOISE_FLOOR  = 64,
  parameter int HOLD_WINDOWS = 5
) (
  input  logic        CLK,
  input  logic        resetn,
  input  logic        samp_clk,
  input  logic [11:0] mic_in,
  output logic [3:0]  level,
  output logic [14:0] led_bar,
  output logic        level_valid
);

  localparam int CW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WINDOW - 1);
  localparam logic [11:0]   MID      = 12'(MIDPOINT);
  localparam logic [10:0]   FLOOR    = 11'(NOISE_FLOOR);

  // Reset asserts immediately but releases only on a clock edge, so no
  // flop sees its reset removed close to an active edge.
  logic [1:0] rst_sync_reg;
  logic       rst_n_int;

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) rst_sync_reg <= 2'b00;
    else         rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end

  assign rst_n_int = rst_sync_reg[1];

  // Two synchroniser stages plus one history stage for edge detection.
  logic [2:0] samp_sync_reg;
  logic       samp_stb;

  always_ff @(posedge CLK or negedge rst_n_int) begin
    if (!rst_n_int) samp_sync_reg <= 3'b000;
    else            samp_sync_reg <= {samp_sync_reg[1:0], samp_clk};
  end

  assign samp_stb = samp_sync_reg[1] & ~samp_sync_reg[2];

  // Magnitude around the DC midpoint. Only mic_in == 0 produces 2048, which
  // is clamped so the value fits the 11-bit peak path.
  logic [11:0] diff;
  logic [10:0] mag_sat;
  logic [10:0] mag;

  assign diff    = (mic_in >= MID) ? (mic_in - MID) : (MID - mic_in);
  assign mag_sat = diff[11] ? 11'h7FF : diff[10:0];
  assign mag     = (mag_sat < FLOOR) ? 11'd0 : mag_sat;

  logic [10:0]   peak_reg, peak_max;
  logic [CW-1:0] cnt_reg;
  logic          win_end;
  logic [3:0]    win_level;
  logic [3:0]    level_next;
  logic [14:0]   led_next;

  // The current sample takes part in the window it closes.
  assign peak_max  = (mag > peak_reg) ? mag : peak_reg;
  assign win_level = peak_max[10:7];
  assign win_end   = samp_stb && (cnt_reg == CNT_LAST);

  always_ff @(posedge CLK or negedge rst_n_int) begin
    if (!rst_n_int) begin
      peak_reg <= '0;
      cnt_reg  <= '0;
    end else if (samp_stb) begin
      if (win_end) begin
        peak_reg <= '0;
        cnt_reg  <= '0;
      end else begin
        peak_reg <= peak_max;
        cnt_reg  <= cnt_reg + 1'b1;
      end
    end
  end

`ifdef PEAK_HOLD_EN
  localparam int HW = (HOLD_WINDOWS > 1) ? $clog2(HOLD_WINDOWS) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_WINDOWS - 1);

  typedef enum logic {HOLD, DECAY} state_t;

  state_t        state_reg, state_next;
  logic [HW-1:0] hold_cnt_reg, hold_cnt_next;

  always_ff @(posedge CLK or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_reg    <= HOLD;
      hold_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  // Evaluated only at window ends. A quieter window counts against the hold
  // budget; once HOLD_WINDOWS quiet windows have been held, DECAY steps the
  // level down by one per window. DECAY is only entered with level >= 1 and
  // returns to HOLD no later than the step that would reach 0, so
  // level - 1 never wraps.
  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    level_next    = level;
    if (win_end) begin
      case (state_reg)
        HOLD: begin
          if (win_level >= level) begin
            level_next    = win_level;
            hold_cnt_next = '0;
          end else if (hold_cnt_reg == HOLD_LAST) begin
            state_next    = DECAY;
            hold_cnt_next = '0;
          end else begin
            hold_cnt_next = hold_cnt_reg + 1'b1;
          end
        end
        DECAY: begin
          if (win_level >= level - 4'd1) begin
            level_next    = win_level;
            hold_cnt_next = '0;
            state_next    = HOLD;
          end else begin
            level_next = level - 4'd1;
          end
        end
        default: begin
          state_next    = HOLD;
          hold_cnt_next = '0;
        end
      endcase
    end
  end
`else
  always_comb begin
    level_next = level;
    if (win_end) level_next = win_level;
  end
`endif

  // The thermometer is derived from the same next-level value, so level and
  // led_bar always change on the same edge.
  for (genvar gi = 0; gi < 15; gi++) begin : g_led
    assign led_next[gi] = (level_next > 4'(gi));
  end

  always_ff @(posedge CLK or negedge rst_n_int) begin
    if (!rst_n_int) begin
      level       <= '0;
      led_bar     <= '0;
      level_valid <= 1'b0;
    end else begin
      level       <= level_next;
      led_bar     <= led_next;
      level_valid <= win_end;
    end
  end

endmodule

// File: tb/tb_mic_volume_meter.sv
// tb_mic_volume_meter
//   Directed bench for mic_volume_meter with WINDOW=8 and HOLD_WINDOWS=2.
//   samp_clk is toggled every few CLK cycles to keep the run short.
//   Expected levels are hand-computed: level = min(|x-2048|, 2047) >> 7.
`timescale 1ns/1ps

module tb_mic_volume_meter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        samp_clk = 1'b0;
  logic [11:0] mic_in = 12'd2048;
  logic [3:0]  level;
  logic [14:0] led_bar;
  logic        level_valid;

  int tests_run = 0;
  int tests_failed = 0;
  int valid_cnt = 0;
  int consec_cnt = 0;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;

  mic_volume_meter #(
    .WINDOW(8), .MIDPOINT(2048), .NOISE_FLOOR(64), .HOLD_WINDOWS(2)
  ) dut (
    .CLK(clk), .resetn(resetn), .samp_clk(samp_clk), .mic_in(mic_in),
    .level(level), .led_bar(led_bar), .level_valid(level_valid)
  );

  // Count level_valid pulses and any back-to-back assertion.
  always @(negedge clk) begin
    if (level_valid) begin
      valid_cnt = valid_cnt + 1;
      if (prev_valid) consec_cnt = consec_cnt + 1;
    end
    prev_valid = level_valid;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  // One sample: mic_in is stable for the whole samp_clk period.
  task automatic strobe(input logic [11:0] v);
    mic_in = v;
    @(negedge clk);
    samp_clk = 1'b1;
    repeat (4) @(negedge clk);
    samp_clk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_window(input logic [11:0] base, input logic [11:0] spike,
                             input int spike_pos);
    for (int i = 0; i < 8; i++) strobe((i == spike_pos) ? spike : base);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    samp_clk = 1'b0;
    mic_in = 12'd2048;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (level !== 4'd0) begin
      tests_failed++; $display("FAIL reset_level: got %0d, expected 0", level);
    end
    tests_run++;
    if (led_bar !== 15'h0000) begin
      tests_failed++; $display("FAIL reset_led_bar: got %h, expected 0000", led_bar);
    end
    tests_run++;
    if (level_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_valid: got %b, expected 0", level_valid);
    end
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    $display("[TB] test_reset done");
  endtask

  task automatic test_silence();
    int v0;
    do_reset();
    v0 = valid_cnt;
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 7; i++) strobe(12'd2048);
      tests_run++;
      if (valid_cnt - v0 !== w) begin
        tests_failed++;
        $display("FAIL silence_early_valid w%0d: got %0d pulses, expected %0d", w, valid_cnt - v0, w);
      end
      strobe(12'd2048);
      tests_run++;
      if (valid_cnt - v0 !== w + 1 || level !== 4'd0 || led_bar !== 15'h0000) begin
        tests_failed++;
        $display("FAIL silence_window w%0d: got pulses=%0d level=%0d led=%h, expected pulses=%0d level=0 led=0000",
                 w, valid_cnt - v0, level, led_bar, w + 1);
      end
    end
    $display("[TB] test_silence done");
  endtask

  task automatic test_full_scale();
    do_reset();
    send_window(12'd2048, 12'd4095, 3);
    tests_run++;
    if (level !== 4'd15 || led_bar !== 15'h7FFF) begin
      tests_failed++;
      $display("FAIL spike_4095: got level=%0d led=%h, expected level=15 led=7fff", level, led_bar);
    end
    do_reset();
    send_window(12'd2048, 12'd0, 5);
    tests_run++;
    if (level !== 4'd15 || led_bar !== 15'h7FFF) begin
      tests_failed++;
      $display("FAIL spike_0_clamp: got level=%0d led=%h, expected level=15 led=7fff", level, led_bar);
    end
    $display("[TB] test_full_scale done");
  endtask

  task automatic test_mid_level();
    do_reset();
    send_window(12'd2560, 12'd2560, -1);
    tests_run++;
    if (level !== 4'd4 || led_bar !== 15'h000F) begin
      tests_failed++;
      $display("FAIL mag512: got level=%0d led=%h, expected level=4 led=000f", level, led_bar);
    end
    do_reset();
    send_window(12'd2111, 12'd2111, -1);
    tests_run++;
    if (level !== 4'd0 || led_bar !== 15'h0000) begin
      tests_failed++;
      $display("FAIL noise_floor: got level=%0d led=%h, expected level=0 led=0000", level, led_bar);
    end
    $display("[TB] test_mid_level done");
  endtask

  task automatic test_reset_midwindow();
    int v0;
    do_reset();
    send_window(12'd4095, 12'd4095, -1);
    tests_run++;
    if (level !== 4'd15) begin
      tests_failed++; $display("FAIL midreset_pre: got level=%0d, expected 15", level);
    end
    for (int i = 0; i < 5; i++) strobe(12'd4095);
    resetn = 1'b0;
    #1;
    tests_run++;
    if (level !== 4'd0 || led_bar !== 15'h0000 || level_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_async: got level=%0d led=%h valid=%b, expected 0 0000 0",
               level, led_bar, level_valid);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    v0 = valid_cnt;
    for (int i = 0; i < 7; i++) strobe(12'd2048);
    tests_run++;
    if (valid_cnt - v0 !== 0) begin
      tests_failed++;
      $display("FAIL midreset_early: got %0d pulses after 7 strobes, expected 0", valid_cnt - v0);
    end
    strobe(12'd2048);
    tests_run++;
    if (valid_cnt - v0 !== 1 || level !== 4'd0) begin
      tests_failed++;
      $display("FAIL midreset_window: got pulses=%0d level=%0d, expected pulses=1 level=0",
               valid_cnt - v0, level);
    end
    $display("[TB] test_reset_midwindow done");
  endtask

`ifdef PEAK_HOLD_EN
  task automatic test_peak_hold();
    logic [3:0]  exp_lvl [5] = '{4'd15, 4'd15, 4'd15, 4'd14, 4'd13};
    logic [14:0] exp_led [5] = '{15'h7FFF, 15'h7FFF, 15'h7FFF, 15'h3FFF, 15'h1FFF};
    do_reset();
    for (int w = 0; w < 5; w++) begin
      if (w == 0) send_window(12'd4095, 12'd4095, -1);
      else        send_window(12'd2048, 12'd2048, -1);
      tests_run++;
      if (level !== exp_lvl[w] || led_bar !== exp_led[w]) begin
        tests_failed++;
        $display("FAIL hold_window%0d: got level=%0d led=%h, expected level=%0d led=%h",
                 w + 1, level, led_bar, exp_lvl[w], exp_led[w]);
      end
    end
    send_window(12'd2048, 12'd4095, 2);
    tests_run++;
    if (level !== 4'd15 || led_bar !== 15'h7FFF) begin
      tests_failed++;
      $display("FAIL hold_restore: got level=%0d led=%h, expected level=15 led=7fff", level, led_bar);
    end
    $display("[TB] test_peak_hold done");
  endtask
`else
  task automatic test_no_hold();
    do_reset();
    send_window(12'd4095, 12'd4095, -1);
    tests_run++;
    if (level !== 4'd15 || led_bar !== 15'h7FFF) begin
      tests_failed++;
      $display("FAIL nohold_loud: got level=%0d led=%h, expected level=15 led=7fff", level, led_bar);
    end
    send_window(12'd2048, 12'd2048, -1);
    tests_run++;
    if (level !== 4'd0 || led_bar !== 15'h0000) begin
      tests_failed++;
      $display("FAIL nohold_silence: got level=%0d led=%h, expected level=0 led=0000", level, led_bar);
    end
    $display("[TB] test_no_hold done");
  endtask
`endif

  task automatic test_valid_width();
    int width;
    do_reset();
    for (int i = 0; i < 7; i++) strobe(12'd2560);
    width = 0;
    mic_in = 12'd2560;
    @(negedge clk);
    samp_clk = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 3) samp_clk = 1'b0;
      if (level_valid) width++;
    end
    tests_run++;
    if (width !== 1) begin
      tests_failed++; $display("FAIL valid_width: got %0d cycles, expected 1", width);
    end
    tests_run++;
    if (consec_cnt !== 0) begin
      tests_failed++; $display("FAIL valid_consecutive: got %0d back-to-back, expected 0", consec_cnt);
    end
    $display("[TB] test_valid_width done");
  endtask

  task automatic test_static();
    int v0;
    do_reset();
    v0 = valid_cnt;
    for (int i = 0; i < 7; i++) strobe(12'd2048);
    mic_in = 12'd4095;
    repeat (200) @(negedge clk);
    tests_run++;
    if (valid_cnt - v0 !== 0 || level !== 4'd0) begin
      tests_failed++;
      $display("FAIL static_hold: got pulses=%0d level=%0d, expected pulses=0 level=0",
               valid_cnt - v0, level);
    end
    strobe(12'd2048);
    tests_run++;
    if (valid_cnt - v0 !== 1 || level !== 4'd0) begin
      tests_failed++;
      $display("FAIL static_resume: got pulses=%0d level=%0d, expected pulses=1 level=0",
               valid_cnt - v0, level);
    end
    $display("[TB] test_static done");
  endtask

  initial begin
    test_reset();
    test_silence();
    test_full_scale();
    test_mid_level();
    test_reset_midwindow();
`ifdef PEAK_HOLD_EN
    test_peak_hold();
`else
    test_no_hold();
`endif
    test_valid_width();
    test_static();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
